// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctlseq_if.sv
// Command handshake and flop-bank async-control pins of the dffrsnq control sequencer.
// The master issues commands; the slave (sequencer) drives the pins and status.
interface gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctlseq_if;
    logic       CMD_VALID;
    logic [1:0] CMD;
    logic       CMD_READY;
    logic       HOLD;
    logic       RN;
    logic       SETN;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    modport master (
        output CMD_VALID, CMD, HOLD,
        input  CMD_READY, RN, SETN, BUSY, DONE, ERR
    );

    modport slave (
        input  CMD_VALID, CMD, HOLD,
        output CMD_READY, RN, SETN, BUSY, DONE, ERR
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctlseq.sv
// Sequences the active-low RN/SETN pins of a dffrsnq bank from set/reset commands,
// guaranteeing a minimum low width, a recovery gap, and mutually exclusive pins.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | pins released, CMD_READY high, NOP/illegal answered in place
//   PULSE   | one pin held low; counter runs down, HOLD stretches at zero
//   RECOVER | both pins high; counter runs down, DONE on exit to IDLE
module gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctlseq #(
    parameter int PW_CYCLES  = 2,
    parameter int REC_CYCLES = 2
) (
    input  logic CLK,
    input  logic RST,
    gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctlseq_if.slave bus
);
    localparam int MAXC = (PW_CYCLES > REC_CYCLES) ? PW_CYCLES : REC_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] PW_LOAD  = CW'(PW_CYCLES - 1);
    localparam logic [CW-1:0] REC_LOAD = CW'(REC_CYCLES - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_RESET = 2'b01;
    localparam logic [1:0] CMD_SET   = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          rn_q, rn_d;
    logic          setn_q, setn_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          cmd_ready;
    logic          accept;
    logic          cnt_zero;

    assign cmd_ready = !RST && (state == IDLE);
    assign accept    = bus.CMD_VALID && cmd_ready;
    assign cnt_zero  = (cnt == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            rn_q   <= 1'b1;
            setn_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            rn_q   <= rn_d;
            setn_q <= setn_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept && (bus.CMD == CMD_RESET || bus.CMD == CMD_SET))
                    state_d = PULSE;
            end
            PULSE: begin
                if (cnt_zero && !bus.HOLD)
                    state_d = RECOVER;
            end
            RECOVER: begin
                if (cnt_zero)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Only the pin selected at accept is ever low, so releasing both at once
    // changes exactly one pin and keeps the pins from toggling together.
    always_comb begin
        cnt_d  = cnt;
        rn_d   = rn_q;
        setn_d = setn_q;
        busy_d = busy_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.CMD)
                        CMD_RESET: begin
                            rn_d   = 1'b0;
                            cnt_d  = PW_LOAD;
                            busy_d = 1'b1;
                        end
                        CMD_SET: begin
                            setn_d = 1'b0;
                            cnt_d  = PW_LOAD;
                            busy_d = 1'b1;
                        end
                        CMD_NOP: done_d = 1'b1;
                        default: err_d  = 1'b1;
                    endcase
                end
            end
            PULSE: begin
                if (!cnt_zero) begin
                    cnt_d = cnt - ONE;
                end else if (!bus.HOLD) begin
                    rn_d   = 1'b1;
                    setn_d = 1'b1;
                    cnt_d  = REC_LOAD;
                end
            end
            RECOVER: begin
                if (!cnt_zero) begin
                    cnt_d = cnt - ONE;
                end else begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign bus.CMD_READY = cmd_ready;
    assign bus.RN        = rn_q;
    assign bus.SETN      = setn_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.ERR       = err_q;
endmodule
